// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared enums and constants for the UART blocks.  Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 16;

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// uart_fifo : synchronous first-word-fall-through FIFO.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry an extra MSB so full and empty differ only in that bit.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_count   = r_wptr - r_rptr;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buf.sv
// ============================================================================
// uart_rx_buf : 16x-oversampled UART receiver with a receive FIFO.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_ODD,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                          mclkx16,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          read,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          rxrdy,
  output logic                          parityerr,
  output logic                          framingerr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int         EW        = DATA_BITS + 2;
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       EXP_PAR   = (PARITY == PAR_ODD);

  logic [1:0]           r_sync;
  logic                 w_rxs;
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [3:0]           r_tcnt;
  logic [3:0]           w_tcnt_nxt;
  logic [2:0]           r_bcnt;
  logic [2:0]           w_bcnt_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 w_ferr_fin;
  logic                 w_shift;
  logic                 w_par_smp;
  logic                 w_stop_smp;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [EW-1:0]        w_head;
  logic                 r_overrun;

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx};
  end
  assign w_rxs = r_sync[1];

  // Second stop sample accumulates into the first; a lone sample starts fresh.
  assign w_ferr_fin = ((r_bcnt == 3'd0) ? 1'b0 : r_ferr) | ~w_rxs;

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt + 4'd1;
    w_bcnt_nxt  = r_bcnt;
    w_shift     = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        w_tcnt_nxt = 4'd0;
        w_bcnt_nxt = 3'd0;
        if (!w_rxs) w_state_nxt = START;
      end
      START: begin
        if (r_tcnt == TICK_MID) begin
          w_tcnt_nxt  = 4'd0;
          w_bcnt_nxt  = 3'd0;
          w_state_nxt = w_rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_tcnt == TICK_LAST) begin
          w_shift    = 1'b1;
          w_bcnt_nxt = r_bcnt + 3'd1;
          if (r_bcnt == LAST_BIT) begin
            w_bcnt_nxt  = 3'd0;
            w_state_nxt = (PARITY == PAR_NONE) ? STOP : PAR;
          end
        end
      end
      PAR: begin
        if (r_tcnt == TICK_LAST) begin
          w_par_smp   = 1'b1;
          w_bcnt_nxt  = 3'd0;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_tcnt == TICK_LAST) begin
          w_stop_smp = 1'b1;
          w_bcnt_nxt = r_bcnt + 3'd1;
          if (r_bcnt == LAST_STOP) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tcnt  <= 4'd0;
      r_bcnt  <= 3'd0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      // LSB arrives first, so shifting in from the top leaves it at bit 0.
      if (w_shift)             r_data <= {w_rxs, r_data[DATA_BITS-1:1]};
      if (r_state == IDLE)     r_perr <= 1'b0;
      else if (w_par_smp)      r_perr <= ((^r_data) ^ w_rxs) != EXP_PAR;
      if (w_stop_smp)          r_ferr <= w_ferr_fin;
    end
  end

  assign w_pop = read & ~w_empty;

  uart_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (mclkx16),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_wdata ({w_ferr_fin, r_perr, r_data}),
    .i_pop   (read),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset)                            r_overrun <= 1'b0;
    else if (w_pop)                        r_overrun <= 1'b0;
    else if (w_push && w_full)             r_overrun <= 1'b1;
  end

  assign rdata      = w_head[DATA_BITS-1:0];
  assign parityerr  = w_head[DATA_BITS];
  assign framingerr = w_head[DATA_BITS+1];
  assign rxrdy      = ~w_empty;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buf.sv
// ============================================================================
// tb_uart_rx_buf : directed checks of uart_rx_buf in 8O1 and 7N2 builds.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_buf;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rd_a, rx_b, rd_b;
  logic [7:0] rdata_a;
  logic [6:0] rdata_b;
  logic       rxrdy_a, perr_a, ferr_a, ovr_a;
  logic       rxrdy_b, perr_b, ferr_b, ovr_b;
  logic [2:0] count_a, count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_buf u_dut_a (
    .mclkx16    (clk),
    .reset      (rst_n),
    .rx         (rx_a),
    .read       (rd_a),
    .rdata      (rdata_a),
    .rxrdy      (rxrdy_a),
    .parityerr  (perr_a),
    .framingerr (ferr_a),
    .overrun    (ovr_a),
    .count      (count_a)
  );

  uart_rx_buf #(
    .DATA_BITS  (7),
    .PARITY     (PAR_NONE),
    .STOP_BITS  (2),
    .FIFO_DEPTH (4)
  ) u_dut_b (
    .mclkx16    (clk),
    .reset      (rst_n),
    .rx         (rx_b),
    .read       (rd_b),
    .rdata      (rdata_b),
    .rxrdy      (rxrdy_b),
    .parityerr  (perr_b),
    .framingerr (ferr_b),
    .overrun    (ovr_b),
    .count      (count_b)
  );

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit which, input logic b);
    @(negedge clk);
    if (which) rx_b = b;
    else       rx_a = b;
    repeat (15) @(negedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input int nbits,
                            input bit has_par, input logic par, input logic stop1,
                            input bit two_stop, input logic stop2);
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, par);
    drive_bit(which, stop1);
    if (two_stop) drive_bit(which, stop2);
    if (which) rx_b = 1'b1;
    else       rx_a = 1'b1;
  endtask

  task automatic pop(input bit which);
    @(negedge clk);
    if (which) rd_b = 1'b1;
    else       rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    rd_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[1] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};

    rx_a = 1'b1; rx_b = 1'b1; rd_a = 1'b0; rd_b = 1'b0; rst_n = 1'b0;
    idle(3);
    chk("rst_rxrdy", {31'd0, rxrdy_a}, 32'd0);
    chk("rst_count", {29'd0, count_a}, 32'd0);
    chk("rst_rdata", {24'd0, rdata_a}, 32'd0);
    chk("rst_flags", {29'd0, ovr_a, perr_a, ferr_a}, 32'd0);
    chk("rst_b",     {28'd0, rxrdy_b, ovr_b, perr_b, ferr_b}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 9; i++) begin
      send_frame(1'b0, vecs[i].d, 8, 1'b1, vecs[i].par, vecs[i].stop, 1'b0, 1'b1);
      chk($sformatf("v%0d_rxrdy", i), {31'd0, rxrdy_a}, 32'd1);
      chk($sformatf("v%0d_count", i), {29'd0, count_a}, 32'd1);
      chk($sformatf("v%0d_rdata", i), {24'd0, rdata_a}, {24'd0, vecs[i].e_data});
      chk($sformatf("v%0d_perr", i),  {31'd0, perr_a},  {31'd0, vecs[i].e_perr});
      chk($sformatf("v%0d_ferr", i),  {31'd0, ferr_a},  {31'd0, vecs[i].e_ferr});
      pop(1'b0);
      chk($sformatf("v%0d_popped", i), {29'd0, rxrdy_a, perr_a, ferr_a}, 32'd0);
      idle(20);
    end

    // False start: low for 4 ticks only.
    @(negedge clk); rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(40);
    chk("false_start_count", {29'd0, count_a}, 32'd0);
    chk("false_start_rxrdy", {31'd0, rxrdy_a}, 32'd0);

    for (int k = 1; k <= 5; k++) begin
      logic [7:0] bv;
      bv = 8'(k);
      send_frame(1'b0, bv, 8, 1'b1, ~^bv, 1'b1, 1'b0, 1'b1);
    end
    idle(2);
    chk("ovr_count", {29'd0, count_a}, 32'd4);
    chk("ovr_flag",  {31'd0, ovr_a},   32'd1);
    chk("ovr_head1", {24'd0, rdata_a}, 32'h01);
    pop(1'b0);
    chk("ovr_clear", {31'd0, ovr_a},   32'd0);
    chk("ovr_head2", {24'd0, rdata_a}, 32'h02);
    chk("ovr_cnt3",  {29'd0, count_a}, 32'd3);
    pop(1'b0);
    chk("ovr_head3", {24'd0, rdata_a}, 32'h03);
    pop(1'b0);
    chk("ovr_head4", {24'd0, rdata_a}, 32'h04);
    pop(1'b0);
    chk("ovr_drained", {28'd0, rxrdy_a, count_a}, 32'd0);
    idle(10);

    send_frame(1'b1, 8'h55, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b_stop2_rdata", {25'd0, rdata_b}, 32'h55);
    chk("b_stop2_flags", {29'd0, rxrdy_b, perr_b, ferr_b}, 32'b101);
    pop(1'b1);
    idle(20);
    send_frame(1'b1, 8'h2A, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("b_clean_rdata", {25'd0, rdata_b}, 32'h2A);
    chk("b_clean_flags", {29'd0, rxrdy_b, perr_b, ferr_b}, 32'b100);
    pop(1'b1);
    idle(20);
    send_frame(1'b1, 8'h33, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b_stop1_rdata", {25'd0, rdata_b}, 32'h33);
    chk("b_stop1_ferr",  {31'd0, ferr_b},  32'd1);
    chk("b_count",       {29'd0, count_b}, 32'd1);
    pop(1'b1);
    chk("b_empty", {28'd0, rxrdy_b, count_b}, 32'd0);
    idle(20);

    // Reset in the middle of a data bit while an older entry is queued.
    send_frame(1'b0, 8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_count", {29'd0, count_a}, 32'd1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    idle(5);
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_count", {29'd0, count_a}, 32'd0);
    chk("mid_rst_out",   {20'd0, rxrdy_a, ovr_a, perr_a, ferr_a, rdata_a}, 32'd0);
    rx_a = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(20);
    send_frame(1'b0, 8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(40);
    chk("post_rst_count", {29'd0, count_a}, 32'd1);
    chk("post_rst_rdata", {24'd0, rdata_a}, 32'hA5);
    chk("post_rst_flags", {29'd0, ovr_a, perr_a, ferr_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_buf.md
# uart_rx_buf

Parametrised successor to `uart_rx`: a 16x-oversampled UART receiver with configurable frame format and an internal receive FIFO. It sits between the asynchronous serial `rx` pin and the host read interface. It checks parity and stop bits for every frame and stores the per-frame error flags alongside each data word. Overrun occurs only when the FIFO itself is full.

## Interface
Parameters:
- `DATA_BITS`, default 8, data bits per frame, legal values 5..8, sent LSB first.
- `PARITY`, default `PAR_ODD`, parity mode: `PAR_NONE`, `PAR_ODD` or `PAR_EVEN`.
- `STOP_BITS`, default 1, stop bits per frame, legal values 1 or 2.
- `FIFO_DEPTH`, default 4, number of receive FIFO entries; must be a power of 2 and at least 2.

Ports:
- `mclkx16`, input, 1, 16x baud clock; the only clock.
- `reset`, input, 1, asynchronous, active-low reset.
- `rx`, input, 1, asynchronous serial input; idles high.
- `read`, input, 1, single-cycle pop strobe; ignored while the FIFO is empty.
- `rdata`, output, `DATA_BITS`, data word at the FIFO head.
- `rxrdy`, output, 1, FIFO not empty.
- `parityerr`, output, 1, parity-error flag of the head entry; always 0 when `PARITY=PAR_NONE`.
- `framingerr`, output, 1, framing-error flag of the head entry.
- `overrun`, output, 1, sticky flag: a completed frame was dropped.
- `count`, output, `$clog2(FIFO_DEPTH)+1`, current number of FIFO entries.

## Operation
- `rx` passes through a 2-flop synchroniser. All decisions use the synchronised signal `rxs`.
- Receive FSM states: `IDLE`, `START`, `DATA`, `PAR`, `STOP`. The 4-bit tick counter `tcnt` and the bit index `bcnt` are local to the FSM.
- `IDLE`: when `rxs==0`, go to `START` with `tcnt=0`.
- `START`: at `tcnt==7` (mid-bit), sample `rxs`.
  - If `rxs==1`, the low pulse was a false start: return to `IDLE`.
  - If `rxs==0`, go to `DATA` with `tcnt=0` and `bcnt=0`.
- `DATA`: at each `tcnt==15`, shift `rxs` into bit `bcnt` of the data register.
  - After sampling bit `DATA_BITS-1`, go to `PAR`, or to `STOP` when `PARITY=PAR_NONE`.
- `PAR`: at `tcnt==15`, sample the parity bit.
  - `parityerr` is set when XOR of the data bits and the parity bit does not equal 1 (odd) or 0 (even).
- `STOP`: at `tcnt==15`, sample the stop bit; `framingerr` is set if it is 0.
  - With `STOP_BITS=2`, the second stop bit is sampled 16 ticks later and ORed into `framingerr`.
  - After the final stop sample, push `{framingerr, parityerr, data}` into the FIFO and return to `IDLE` in the same cycle. This allows a start bit that immediately follows the stop bit to be detected.
- FIFO:
  - First-word fall-through: `rdata`, `parityerr` and `framingerr` always reflect the head entry and are 0 when the FIFO is empty.
  - `read` while `rxrdy==1` pops the head entry.
- Overrun:
  - A push while the FIFO is full, with no pop in the same cycle, drops the new frame and sets `overrun`.
  - `overrun` clears on the next accepted `read`.
- Simultaneous push and pop:
  - When full: both are accepted, `count` is unchanged, and no overrun is flagged.
  - When empty: only the push takes effect.
- Reset (asynchronous, any time including mid-frame):
  - FSM goes to `IDLE`; counters are cleared; FIFO is emptied; synchroniser flops are set to 1.
  - All outputs are 0: `rdata`, `rxrdy`, `parityerr`, `framingerr`, `overrun`, `count`.

## Timing
- Frame length is `16*(1+DATA_BITS+P+STOP_BITS)` ticks, where P=1 when parity is enabled and 0 otherwise. The FSM is ready for the next start bit from mid-stop-bit.
- Latency from an `rx` edge to `rxs`: 2 cycles. Each bit is sampled 8 ticks (±1) after its nominal edge.
- Push occurs on the edge of the final stop sample; `rxrdy`, `count` and the head data update on that same edge.
- Pop: `rdata` and the flags show the next entry on the edge after `read`. `rxrdy` falls on that edge if the FIFO is now empty.
- Wrap-around: read and write pointers carry one extra MSB. Full is detected as MSBs differing with equal lower bits.

## Structure
- Package `uart_pkg`: parity enum `parity_e`, FSM enum `rx_state_e`, and constant `OVERSAMPLE=16`.
- Sub-module `uart_fifo`: parameterised synchronous FWFT FIFO (width, depth) with push, pop, full, empty and count. It will be reused by the transmitter.

## Test plan
- 8O1, `rx` frame carrying 0x0F with parity bit 1 -> `rdata=0x0F`, `rxrdy=1`, `parityerr=0`, `framingerr=0`.
- Same frame with parity bit 0 -> `rdata=0x0F`, `parityerr=1`; a frame with stop bit 0 -> `framingerr=1`. Each flag clears when its entry is popped.
- `rx` low for 4 ticks, then high -> FSM returns to `IDLE`, no push, `count=0`.
- `FIFO_DEPTH=4`, 5 back-to-back frames of 0x01..0x05 with no reads -> `count=4`, `overrun=1`, reads return 0x01..0x04, and `overrun` clears after the first read.
- `DATA_BITS=7`, `PAR_NONE`, `STOP_BITS=2`, frame 0x55 with the second stop bit 0 -> `rdata=0x55`, `framingerr=1`.
- Reset asserted mid-data-bit of a frame, released, then a clean 0xA5 frame -> only 0xA5 is received, `count=1`.
